// File: rtl/rgb444_dither.sv
// rgb444_dither: ordered 4x4 Bayer dither from 8-bit to 4-bit per channel.
// Each 4-bit result is replicated into both nibbles of its byte so that the
// downstream r[7:4]/g[7:4]/b[7:4] pin mapping sees the quantised value.
// The pixel path and the syncs share one fixed 2-cycle delay. There are no
// stalls and no handshake: one pixel is accepted on every clock.
module rgb444_dither #(
    parameter bit TEMPORAL_EN = 1'b1,
    parameter bit VS_ACTIVE   = 1'b1
) (
    input  logic        clk_40m_tree,
    input  logic        reset_loc,
    input  logic        dither_en,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [23:0] in_rgb,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [23:0] out_rgb,
    output logic [1:0]  frame_cnt
);

    // Bayer matrix, flattened row-major: index = {y, x}.
    localparam logic [3:0] BAYER [0:15] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    logic [1:0]  r_x;
    logic [1:0]  r_y;
    logic [1:0]  r_frame_cnt;
    logic        r_de_d;
    logic        r_vs_d;
    logic        r_dither_en_q;

    logic [23:0] r_s1_rgb;
    logic [3:0]  r_s1_t;
    logic        r_s1_de;
    logic        r_s1_hs;
    logic        r_s1_vs;

    logic        r_out_de;
    logic        r_out_hs;
    logic        r_out_vs;
    logic [23:0] r_out_rgb;

    logic        w_vs_edge;
    logic [1:0]  w_xi;
    logic [3:0]  w_t;
    logic [3:0]  w_q_r;
    logic [3:0]  w_q_g;
    logic [3:0]  w_q_b;

    // Add the threshold and keep the top nibble; a carry out saturates to F
    // so bright pixels never wrap to black.
    function automatic logic [3:0] quant(input logic [7:0] c, input logic [3:0] t,
                                         input logic en);
        logic [8:0] s;
        s = {1'b0, c} + {5'd0, t};
        if (!en)
            return c[7:4];
        else if (s[8])
            return 4'hF;
        else
            return s[7:4];
    endfunction

    // The frame boundary is the leading edge of the vertical sync pulse.
    assign w_vs_edge = (in_vs == VS_ACTIVE) && (r_vs_d != VS_ACTIVE);
    // The frame counter shifts the pattern horizontally when temporal mode is on.
    assign w_xi      = TEMPORAL_EN ? (r_x + r_frame_cnt) : r_x;
    assign w_t       = BAYER[{r_y, w_xi}];

    assign w_q_r = quant(r_s1_rgb[23:16], r_s1_t, r_dither_en_q);
    assign w_q_g = quant(r_s1_rgb[15:8],  r_s1_t, r_dither_en_q);
    assign w_q_b = quant(r_s1_rgb[7:0],   r_s1_t, r_dither_en_q);

    // Pixel/line/frame position tracking and the per-frame enable latch.
    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            r_x           <= 2'd0;
            r_y           <= 2'd0;
            r_frame_cnt   <= 2'd0;
            r_de_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_dither_en_q <= 1'b0;
        end else begin
            r_de_d <= in_de;
            r_vs_d <= in_vs;
            r_x    <= in_de ? (r_x + 2'd1) : 2'd0;
            // Frame boundary wins over a coincident end of line.
            if (w_vs_edge)
                r_y <= 2'd0;
            else if (r_de_d && !in_de)
                r_y <= r_y + 2'd1;
            if (w_vs_edge) begin
                r_frame_cnt   <= r_frame_cnt + 2'd1;
                r_dither_en_q <= dither_en;
            end
        end
    end

    // Stage 1: capture the pixel, its threshold and the syncs.
    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            r_s1_rgb <= 24'd0;
            r_s1_t   <= 4'd0;
            r_s1_de  <= 1'b0;
            r_s1_hs  <= 1'b0;
            r_s1_vs  <= 1'b0;
        end else begin
            r_s1_rgb <= in_rgb;
            r_s1_t   <= w_t;
            r_s1_de  <= in_de;
            r_s1_hs  <= in_hs;
            r_s1_vs  <= in_vs;
        end
    end

    // Stage 2: quantise, replicate nibbles, and force black outside active video.
    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            r_out_de  <= 1'b0;
            r_out_hs  <= 1'b0;
            r_out_vs  <= 1'b0;
            r_out_rgb <= 24'd0;
        end else begin
            r_out_de  <= r_s1_de;
            r_out_hs  <= r_s1_hs;
            r_out_vs  <= r_s1_vs;
            r_out_rgb <= r_s1_de ? {w_q_r, w_q_r, w_q_g, w_q_g, w_q_b, w_q_b} : 24'd0;
        end
    end

    assign out_de    = r_out_de;
    assign out_hs    = r_out_hs;
    assign out_vs    = r_out_vs;
    assign out_rgb   = r_out_rgb;
    assign frame_cnt = r_frame_cnt;

endmodule
